// File: rtl/mdu_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit: operand width,
// op and state encodings, and op-decode helpers.
package mdu_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } state_e;

  function automatic logic op_is_signed(input op_e op);
    return ~op[0];
  endfunction

  function automatic logic op_is_div(input op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// One combinational iteration: radix-2 shift-add multiply or restoring
// divide step, selected by is_div.
module mdu_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic                 is_div,
  input  logic [2*WIDTH-1:0]   acc_in,
  input  logic [WIDTH-1:0]     rem_in,
  input  logic [WIDTH-1:0]     opnd,
  output logic [2*WIDTH-1:0]   acc_out,
  output logic [WIDTH-1:0]     rem_out
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    // Multiply: acc = {partial product, remaining multiplier bits}
    sum     = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, opnd} : '0);
    // Divide: low word of acc shifts the dividend out and the quotient in
    shifted = {rem_in, acc_in[WIDTH-1]};
    ge      = (shifted >= {1'b0, opnd});
    diff    = shifted[WIDTH-1:0] - opnd;
    acc_out = {sum, acc_in[WIDTH-1:1]};
    rem_out = rem_in;
    if (is_div) begin
      acc_out = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-2:0], ge};
      rem_out = ge ? diff : shifted[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers and a
// start/busy/done handshake toward the control FSM.
//
// state  | meaning
// S_IDLE | waiting for start; MTHI/MTLO writes accepted
// S_CALC | one shift-add / restore-subtract iteration per cycle
// S_FIX  | sign correction and HI/LO write, done pulse follows
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = mdu_pkg::WIDTH,
  parameter int CNT_W = mdu_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 is_div_q, is_div_d;
  logic                 is_signed_q, is_signed_d;
  logic                 sign_a_q, sign_a_d;
  logic                 sign_b_q, sign_b_d;
  logic                 bzero_q, bzero_d;
  logic [WIDTH-1:0]     a_raw_q, a_raw_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;
  logic                 div_zero_q, div_zero_d;

  logic [2*WIDTH-1:0]   acc_step;
  logic [WIDTH-1:0]     rem_step;
  logic                 start_signed, start_div;
  logic [WIDTH-1:0]     a_abs, b_abs;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  mdu_iter_core #(.WIDTH(WIDTH)) u_iter (
    .is_div  (is_div_q),
    .acc_in  (acc_q),
    .rem_in  (rem_q),
    .opnd    (opnd_q),
    .acc_out (acc_step),
    .rem_out (rem_step)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_CALC;
      S_CALC:  if (cnt_q == '0) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != S_IDLE);
    done     = done_q;
    div_zero = div_zero_q;
    hi       = hi_q;
    lo       = lo_q;
  end

  always_comb begin
    start_signed = op_is_signed(op_e'(op));
    start_div    = op_is_div(op_e'(op));
    a_abs        = (start_signed && src_a[WIDTH-1]) ? -src_a : src_a;
    b_abs        = (start_signed && src_b[WIDTH-1]) ? -src_b : src_b;

    prod_fix = (is_signed_q && (sign_a_q ^ sign_b_q)) ? -acc_q : acc_q;
    quo_fix  = (is_signed_q && (sign_a_q ^ sign_b_q)) ? -acc_q[WIDTH-1:0]
                                                      : acc_q[WIDTH-1:0];
    rem_fix  = (is_signed_q && sign_a_q) ? -rem_q : rem_q;

    cnt_d       = cnt_q;
    is_div_d    = is_div_q;
    is_signed_d = is_signed_q;
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
    bzero_d     = bzero_q;
    a_raw_d     = a_raw_q;
    opnd_d      = opnd_q;
    acc_d       = acc_q;
    rem_d       = rem_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    done_d      = 1'b0;
    div_zero_d  = div_zero_q;

    unique case (state_q)
      S_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          is_div_d    = start_div;
          is_signed_d = start_signed;
          sign_a_d    = start_signed & src_a[WIDTH-1];
          sign_b_d    = start_signed & src_b[WIDTH-1];
          bzero_d     = (src_b == '0);
          a_raw_d     = src_a;
          div_zero_d  = 1'b0;
          cnt_d       = CNT_W'(WIDTH-1);
          rem_d       = '0;
          opnd_d      = start_div ? b_abs : a_abs;
          acc_d       = {{WIDTH{1'b0}}, (start_div ? a_abs : b_abs)};
        end
      end
      S_CALC: begin
        acc_d = acc_step;
        rem_d = rem_step;
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      end
      S_FIX: begin
        done_d = 1'b1;
        if (!is_div_q) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (bzero_q) begin
          // divide by zero reports the raw dividend, not sign-corrected
          hi_d       = a_raw_q;
          lo_d       = '1;
          div_zero_d = 1'b1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= '0;
      is_div_q    <= 1'b0;
      is_signed_q <= 1'b0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      bzero_q     <= 1'b0;
      a_raw_q     <= '0;
      opnd_q      <= '0;
      acc_q       <= '0;
      rem_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      done_q      <= 1'b0;
      div_zero_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      is_div_q    <= is_div_d;
      is_signed_q <= is_signed_d;
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
      bzero_q     <= bzero_d;
      a_raw_q     <= a_raw_d;
      opnd_q      <= opnd_d;
      acc_q       <= acc_d;
      rem_q       <= rem_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      done_q      <= done_d;
      div_zero_q  <= div_zero_d;
    end
  end

endmodule
